// File: rtl/frame_bank_scheduler_pkg.sv
// Shared bank codes and helpers for the triple-buffered frame memory scheduler.
package frame_bank_scheduler_pkg;
  localparam int BANK_W       = 2;
  localparam int FRAME_PIXELS = 76800;

  typedef enum logic [BANK_W-1:0] {
    BANK0 = 2'd0,
    BANK1 = 2'd1,
    BANK2 = 2'd2
  } bank_e;

  // Returns the one bank among BANK0..BANK2 that is neither a nor b.
  function automatic bank_e third_bank(input bank_e a, input bank_e b);
    if (a != BANK0 && b != BANK0) return BANK0;
    if (a != BANK1 && b != BANK1) return BANK1;
    return BANK2;
  endfunction
endpackage

// File: rtl/frame_bank_scheduler_port_arb.sv
// Single-port memory arbiter: writer has priority, mem_* registered, read-valid delay pipe.
module frame_bank_scheduler_port_arb
  import frame_bank_scheduler_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  bank_e                    w_bank,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  bank_e                    r_bank,
  input  logic                     reader_active,
  output logic                     rd_ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W+BANK_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int STAGES = 2;

  logic                     mem_en_d, mem_we_d;
  logic [ADDR_W+BANK_W-1:0] mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_d;
  logic [STAGES:1]          vld_pipe_d, vld_pipe_q;

  always_comb begin
    rd_ack      = rd_req & reader_active & ~wr_req;
    mem_en_d    = wr_req | rd_ack;
    mem_we_d    = wr_req;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (wr_req) begin
      mem_addr_d  = {w_bank, wr_addr};
      mem_wdata_d = wr_data;
    end else if (rd_ack) begin
      mem_addr_d  = {r_bank, rd_addr};
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], rd_ack};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vld_pipe_q <= '0;
    end else begin
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Read data comes straight from the synchronous memory; gated so it reads 0 when not valid.
  assign rd_valid = vld_pipe_q[STAGES];
  assign rd_data  = rd_valid ? mem_rdata : '0;
endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler: tracks writer/ready/reader bank roles, grants frames, counts drops.
module frame_bank_scheduler
  import frame_bank_scheduler_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int DROP_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_sof,
  input  logic                     wr_eof,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_frame_req,
  output logic                     rd_frame_gnt,
  input  logic                     rd_done,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W+BANK_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     frame_ready,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);
  bank_e                 w_bank_d, w_bank_q, ready_bank_d, ready_bank_q, r_bank_d, r_bank_q;
  logic                  ready_valid_d, ready_valid_q, reader_active_d, reader_active_q;
  logic                  wr_in_frame_d, wr_in_frame_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;
  logic                  grant, eof_ok;

  always_comb begin
    grant           = rd_frame_req & ready_valid_q & ~reader_active_q;
    eof_ok          = wr_eof & wr_in_frame_q;
    w_bank_d        = w_bank_q;
    ready_bank_d    = ready_bank_q;
    r_bank_d        = r_bank_q;
    ready_valid_d   = ready_valid_q;
    reader_active_d = reader_active_q;
    wr_in_frame_d   = wr_in_frame_q;
    drop_cnt_d      = drop_cnt_q;

    if (grant) begin
      r_bank_d        = ready_bank_q;
      reader_active_d = 1'b1;
      ready_valid_d   = 1'b0;
    end else if (rd_done) begin
      reader_active_d = 1'b0;
    end

    // With a reader holding a bank the writer takes the remaining one; otherwise it
    // avoids the bank just retired from ready, so an idle reader sees a 0->1->2 rotation.
    if (eof_ok) begin
      ready_bank_d  = w_bank_q;
      ready_valid_d = 1'b1;
      w_bank_d      = third_bank(w_bank_q, reader_active_q ? r_bank_q : ready_bank_q);
      wr_in_frame_d = 1'b0;
      if (ready_valid_q && !grant && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (wr_sof) wr_in_frame_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_bank_q        <= BANK0;
      ready_bank_q    <= BANK2;
      r_bank_q        <= BANK1;
      ready_valid_q   <= 1'b0;
      reader_active_q <= 1'b0;
      wr_in_frame_q   <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      w_bank_q        <= w_bank_d;
      ready_bank_q    <= ready_bank_d;
      r_bank_q        <= r_bank_d;
      ready_valid_q   <= ready_valid_d;
      reader_active_q <= reader_active_d;
      wr_in_frame_q   <= wr_in_frame_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign rd_frame_gnt = grant;
  assign frame_ready  = ready_valid_q;
  assign drop_cnt     = drop_cnt_q;

  frame_bank_scheduler_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
    .clk           (clk),
    .rst           (rst),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .w_bank        (w_bank_q),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .r_bank        (r_bank_q),
    .reader_active (reader_active_q),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: port-arbitration table plus bank-role sequences.
module tb_frame_bank_scheduler;
  logic        clk = 1'b0, rst = 1'b0;
  logic        wr_sof = 0, wr_eof = 0, wr_req = 0, rd_frame_req = 0, rd_done = 0, rd_req = 0;
  logic [16:0] wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0, mem_rdata = '0;
  logic        rd_frame_gnt, rd_ack, rd_valid, mem_en, mem_we, frame_ready;
  logic [7:0]  rd_data, mem_wdata, drop_cnt;
  logic [18:0] mem_addr;
  int          n_vec = 0, n_bad = 0;

  frame_bank_scheduler dut (
    .clk(clk), .rst(rst), .wr_sof(wr_sof), .wr_eof(wr_eof), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_frame_req(rd_frame_req),
    .rd_frame_gnt(rd_frame_gnt), .rd_done(rd_done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .frame_ready(frame_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: reads return a pattern derived from the address.
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic wr, rd; logic [16:0] wa, ra; logic [7:0] wd;
    logic ack, en, we; logic [18:0] addr; logic [7:0] wdat;
  } vec_t;
  vec_t tbl[6];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; {wr_sof, wr_eof, wr_req, rd_frame_req, rd_done, rd_req} = '0;
    #1;
    chk("rst_frame_ready", frame_ready, 0); chk("rst_drop", drop_cnt, 0);
    chk("rst_mem_en", mem_en, 0);          chk("rst_rd_valid", rd_valid, 0);
    chk("rst_gnt", rd_frame_gnt, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic do_frame();
    wr_sof = 1; tick(); wr_sof = 0; tick();
    wr_eof = 1; tick(); wr_eof = 0;
  endtask

  task automatic probe_wbank(input logic [1:0] b);
    wr_req = 1; wr_addr = 17'h00042; wr_data = 8'h3C; tick(); wr_req = 0;
    chk("wbank_en", mem_en, 1); chk("wbank_we", mem_we, 1);
    chk("wbank_id", mem_addr[18:17], b); chk("wbank_data", mem_wdata, 8'h3C);
  endtask

  task automatic probe_rbank(input logic [1:0] b);
    rd_req = 1; rd_addr = 17'h00017; #1;
    chk("rbank_ack", rd_ack, 1);
    tick(); rd_req = 0;
    chk("rbank_we", mem_we, 0); chk("rbank_id", mem_addr[18:17], b);
  endtask

  task automatic grant_now();
    rd_frame_req = 1; #1;
    chk("gnt_now", rd_frame_gnt, 1);
    tick(); rd_frame_req = 0; #1;
    chk("gnt_single", rd_frame_gnt, 0); chk("gnt_ready_clr", frame_ready, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 17'd5,     17'd0,       8'hAA, 1'b0, 1'b1, 1'b1, {2'd1, 17'd5},       8'hAA};
    tbl[1] = '{1'b0, 1'b1, 17'd0,     17'd7,       8'h00, 1'b1, 1'b1, 1'b0, {2'd0, 17'd7},       8'h00};
    tbl[2] = '{1'b1, 1'b1, 17'd9,     17'd3,       8'h33, 1'b0, 1'b1, 1'b1, {2'd1, 17'd9},       8'h33};
    tbl[3] = '{1'b0, 1'b0, 17'd4,     17'd4,       8'h11, 1'b0, 1'b0, 1'b0, 19'd0,               8'h00};
    tbl[4] = '{1'b0, 1'b1, 17'd0,     17'h1FFFF,   8'h00, 1'b1, 1'b1, 1'b0, {2'd0, 17'h1FFFF},   8'h00};
    tbl[5] = '{1'b1, 1'b0, 17'd76799, 17'd0,       8'hFF, 1'b0, 1'b1, 1'b1, {2'd1, 17'd76799},   8'hFF};

    // First frame after reset
    do_reset();
    do_frame();
    chk("t1_ready", frame_ready, 1); chk("t1_drop", drop_cnt, 0);
    probe_wbank(2'd1);
    grant_now();
    probe_rbank(2'd0);

    // Three frames with no reader
    do_reset();
    repeat (3) do_frame();
    chk("t2_drop", drop_cnt, 2); chk("t2_ready", frame_ready, 1);
    probe_wbank(2'd0);
    grant_now();
    probe_rbank(2'd2);

    // Request pending before the frame completes
    do_reset();
    rd_frame_req = 1;
    wr_sof = 1; tick(); wr_sof = 0;
    wr_eof = 1; #1; chk("t3_no_early_gnt", rd_frame_gnt, 0);
    tick(); wr_eof = 0; #1;
    chk("t3_gnt", rd_frame_gnt, 1); chk("t3_ready_set", frame_ready, 1);
    tick(); rd_frame_req = 0; #1;
    chk("t3_gnt_drop", rd_frame_gnt, 0); chk("t3_ready_clr", frame_ready, 0);
    probe_rbank(2'd0);

    // Writer always wins, then a lone read returns data two cycles after ack
    for (int i = 0; i < 10; i++) begin
      wr_req = 1; rd_req = 1; wr_addr = 17'(i); rd_addr = 17'(i + 100); #1;
      chk("t4_rd_blocked", rd_ack, 0);
      tick();
    end
    wr_req = 0; rd_req = 1; rd_addr = 17'h00123; #1;
    chk("t4_rd_ack", rd_ack, 1);
    tick(); rd_req = 0;
    chk("t4_mem_addr", mem_addr, {2'd0, 17'h00123}); chk("t4_valid_early", rd_valid, 0);
    tick();
    chk("t4_valid", rd_valid, 1); chk("t4_rdata", rd_data, 8'h23 ^ 8'h5A);
    tick();
    chk("t4_valid_end", rd_valid, 0);

    // Arbitration table (reader active on bank 0, writer on bank 1)
    for (int i = 0; i < 6; i++) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd; wr_addr = tbl[i].wa;
      rd_addr = tbl[i].ra; wr_data = tbl[i].wd; #1;
      chk($sformatf("tbl%0d_ack", i), rd_ack, tbl[i].ack);
      tick();
      chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].en);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].wdat);
    end
    wr_req = 0; rd_req = 0;

    // wr_eof coinciding with a grant
    do_reset();
    do_frame();
    wr_sof = 1; tick(); wr_sof = 0; tick();
    wr_eof = 1; rd_frame_req = 1; #1;
    chk("t5_gnt", rd_frame_gnt, 1);
    tick(); wr_eof = 0; rd_frame_req = 0; #1;
    chk("t5_ready", frame_ready, 1); chk("t5_no_drop", drop_cnt, 0);
    probe_wbank(2'd2);
    probe_rbank(2'd0);
    rd_done = 1; tick(); rd_done = 0;
    grant_now();
    probe_rbank(2'd1);
    do_frame();
    probe_wbank(2'd0);
    rd_frame_req = 1; rd_done = 1; #1;
    chk("t5_gnt_busy", rd_frame_gnt, 0);
    tick(); rd_done = 0; #1;
    chk("t5_gnt_after_done", rd_frame_gnt, 1);
    tick(); rd_frame_req = 0;
    probe_rbank(2'd2);

    // Reset mid-frame, then a stray eof
    do_reset();
    wr_sof = 1; tick(); wr_sof = 0; tick();
    rst = 0; #1;
    chk("t6_rst_ready", frame_ready, 0);
    tick(); rst = 1; tick();
    wr_eof = 1; tick(); wr_eof = 0;
    chk("t6_eof_ignored", frame_ready, 0); chk("t6_drop", drop_cnt, 0);
    probe_wbank(2'd0);
    do_frame();
    chk("t6_next_frame", frame_ready, 1);

    // Drop counter saturation
    do_reset();
    repeat (258) do_frame();
    chk("sat_drop", drop_cnt, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
